// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : timer_ctrl_pkg
// Desc   : Shared widths, reset constants and control-field record for the
//          timer sequencing and interrupt controller.
// Rev    : 1.0
// ============================================================================
package timer_ctrl_pkg;

    localparam int CNT_W   = 64;
    localparam int DIV_W   = 4;
    localparam int DIV_MAX = 8;

    localparam logic [CNT_W-1:0] c_cmp_rst     = '1;
    localparam logic [DIV_W-1:0] c_div_val_rst = DIV_W'(1);

    typedef struct packed {
        logic             timer_en;
        logic             div_en;
        logic [DIV_W-1:0] div_val;
    } ctrl_fields_t;

    localparam ctrl_fields_t c_ctrl_rst = '{timer_en: 1'b0,
                                           div_en:   1'b0,
                                           div_val:  c_div_val_rst};

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module : timer_prescaler
// Desc   : Power-of-two prescaler producing the counter strobe; the divider
//          state freezes while halted and clears whenever the timer is off.
// Rev    : 1.0
// ============================================================================
module timer_prescaler #(
    parameter int DIV_W   = timer_ctrl_pkg::DIV_W,
    parameter int DIV_MAX = timer_ctrl_pkg::DIV_MAX
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             timer_en,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             halt,
    output logic             cnt_en
);

    logic [DIV_MAX-1:0] r_div_cnt;
    logic [DIV_MAX-1:0] w_div_cnt_nxt;
    logic [DIV_MAX:0]   w_span;
    logic [DIV_MAX-1:0] w_term;
    logic               w_at_term;

    // Terminal count is 2^div_val - 1; div_val=DIV_MAX wraps to all ones.
    assign w_span    = (DIV_MAX + 1)'(1) << div_val;
    assign w_term    = DIV_MAX'(w_span - {{DIV_MAX{1'b0}}, 1'b1});
    assign w_at_term = (r_div_cnt == w_term);

    always_comb begin
        cnt_en        = 1'b0;
        w_div_cnt_nxt = r_div_cnt;
        if (!timer_en || !div_en) begin
            w_div_cnt_nxt = '0;
            cnt_en        = timer_en && !halt;
        end else if (!halt) begin
            cnt_en        = w_at_term;
            w_div_cnt_nxt = w_at_term ? '0 : r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : timer_ctrl
// Desc   : Control-field, compare and sticky interrupt logic for the 64-bit
//          timer; drives the counter enable and count strobes.
// Rev    : 1.0
// ============================================================================
module timer_ctrl #(
    parameter int CNT_W   = timer_ctrl_pkg::CNT_W,
    parameter int DIV_W   = timer_ctrl_pkg::DIV_W,
    parameter int DIV_MAX = timer_ctrl_pkg::DIV_MAX
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ctrl_we,
    input  logic             ctrl_timer_en_i,
    input  logic             ctrl_div_en_i,
    input  logic [DIV_W-1:0] ctrl_div_val_i,
    input  logic             cmp0_we,
    input  logic             cmp1_we,
    input  logic [31:0]      cmp_wdata,
    input  logic             int_en_we,
    input  logic             int_en_i,
    input  logic             int_st_clr,
    input  logic             dbg_mode,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] counter_value,
    output logic             timer_en,
    output logic             cnt_en,
    output logic             div_en,
    output logic [DIV_W-1:0] div_val,
    output logic [CNT_W-1:0] compare,
    output logic             int_en,
    output logic             int_st,
    output logic             tim_int,
    output logic             halt_ack,
    output logic             ctrl_err
);
    import timer_ctrl_pkg::*;

    ctrl_fields_t     r_ctrl;
    logic [CNT_W-1:0] r_compare;
    logic             r_int_en;
    logic             r_int_st;
    logic             r_halt_ack;
    logic             r_ctrl_err;

    logic             w_div_illegal;
    logic             w_locked;
    logic             w_ctrl_reject;
    logic             w_ctrl_accept;
    logic             w_match;

    // Divider fields are frozen while the timer runs; timer_en alone may change.
    assign w_div_illegal = ctrl_div_val_i > DIV_W'(DIV_MAX);
    assign w_locked      = r_ctrl.timer_en &&
                           ((ctrl_div_en_i != r_ctrl.div_en) ||
                            (ctrl_div_val_i != r_ctrl.div_val));
    assign w_ctrl_reject = ctrl_we && (w_div_illegal || w_locked);
    assign w_ctrl_accept = ctrl_we && !w_ctrl_reject;
    assign w_match       = (counter_value == r_compare);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl     <= c_ctrl_rst;
            r_ctrl_err <= 1'b0;
            r_halt_ack <= 1'b0;
        end else begin
            if (w_ctrl_accept) begin
                r_ctrl.timer_en <= ctrl_timer_en_i;
                r_ctrl.div_en   <= ctrl_div_en_i;
                r_ctrl.div_val  <= ctrl_div_val_i;
            end
            r_ctrl_err <= w_ctrl_reject;
            r_halt_ack <= dbg_mode && halt_req;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_compare <= c_cmp_rst;
            r_int_en  <= 1'b0;
            r_int_st  <= 1'b0;
        end else begin
            if (cmp0_we) begin
                r_compare[31:0] <= cmp_wdata;
            end
            if (cmp1_we) begin
                r_compare[CNT_W-1:32] <= cmp_wdata[CNT_W-33:0];
            end
            if (int_en_we) begin
                r_int_en <= int_en_i;
            end
            // A new match takes precedence over a clear in the same cycle.
            if (w_match) begin
                r_int_st <= 1'b1;
            end else if (int_st_clr) begin
                r_int_st <= 1'b0;
            end
        end
    end

    timer_prescaler #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .timer_en (r_ctrl.timer_en),
        .div_en   (r_ctrl.div_en),
        .div_val  (r_ctrl.div_val),
        .halt     (r_halt_ack),
        .cnt_en   (cnt_en)
    );

    assign timer_en = r_ctrl.timer_en;
    assign div_en   = r_ctrl.div_en;
    assign div_val  = r_ctrl.div_val;
    assign compare  = r_compare;
    assign int_en   = r_int_en;
    assign int_st   = r_int_st;
    assign tim_int  = r_int_st & r_int_en;
    assign halt_ack = r_halt_ack;
    assign ctrl_err = r_ctrl_err;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_timer_ctrl
// Desc   : Self-checking bench: control-write vector table, cnt_en scoreboard
//          and directed compare / halt / reset sequences.
// Rev    : 1.0
// ============================================================================
module tb_timer_ctrl;

    logic        CLK;
    logic        RST;
    logic        ctrl_we;
    logic        ctrl_timer_en_i;
    logic        ctrl_div_en_i;
    logic [3:0]  ctrl_div_val_i;
    logic        cmp0_we;
    logic        cmp1_we;
    logic [31:0] cmp_wdata;
    logic        int_en_we;
    logic        int_en_i;
    logic        int_st_clr;
    logic        dbg_mode;
    logic        halt_req;
    logic [63:0] counter_value;
    logic        timer_en;
    logic        cnt_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic [63:0] compare;
    logic        int_en;
    logic        int_st;
    logic        tim_int;
    logic        halt_ack;
    logic        ctrl_err;

    int   n_total;
    int   n_pass;
    logic mon_en;
    logic sb[$];

    typedef struct {
        logic       te;
        logic       de;
        logic [3:0] dv;
        logic       exp_te;
        logic       exp_de;
        logic [3:0] exp_dv;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    timer_ctrl dut (
        .CLK             (CLK),
        .RST             (RST),
        .ctrl_we         (ctrl_we),
        .ctrl_timer_en_i (ctrl_timer_en_i),
        .ctrl_div_en_i   (ctrl_div_en_i),
        .ctrl_div_val_i  (ctrl_div_val_i),
        .cmp0_we         (cmp0_we),
        .cmp1_we         (cmp1_we),
        .cmp_wdata       (cmp_wdata),
        .int_en_we       (int_en_we),
        .int_en_i        (int_en_i),
        .int_st_clr      (int_st_clr),
        .dbg_mode        (dbg_mode),
        .halt_req        (halt_req),
        .counter_value   (counter_value),
        .timer_en        (timer_en),
        .cnt_en          (cnt_en),
        .div_en          (div_en),
        .div_val         (div_val),
        .compare         (compare),
        .int_en          (int_en),
        .int_st          (int_st),
        .tim_int         (tim_int),
        .halt_ack        (halt_ack),
        .ctrl_err        (ctrl_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One cycle of control stimulus plus the cnt_en value expected in that cycle.
    task automatic cyc(input logic we, input logic te, input logic de,
                       input logic [3:0] dv, input logic hr, input logic exp);
        tick();
        ctrl_we         = we;
        ctrl_timer_en_i = te;
        ctrl_div_en_i   = de;
        ctrl_div_val_i  = dv;
        dbg_mode        = hr;
        halt_req        = hr;
        sb.push_back(exp);
    endtask

    task automatic drain();
        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        chk("sb_leftover", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_timer_en"}, timer_en, 1'b0);
        chk({tag, "_cnt_en"},   cnt_en,   1'b0);
        chk({tag, "_div_en"},   div_en,   1'b0);
        chk({tag, "_div_val"},  div_val,  4'd1);
        chk({tag, "_compare"},  compare,  64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_int_en"},   int_en,   1'b0);
        chk({tag, "_int_st"},   int_st,   1'b0);
        chk({tag, "_tim_int"},  tim_int,  1'b0);
        chk({tag, "_halt_ack"}, halt_ack, 1'b0);
        chk({tag, "_ctrl_err"}, ctrl_err, 1'b0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                chk("cnt_en", cnt_en, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        mon_en  = 1'b0;

        //            te    de    dv     exp_te exp_de exp_dv exp_err
        vecs[0] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 4'd2, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 4'd8, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0};

        RST = 1'b1;
        ctrl_we = 0; ctrl_timer_en_i = 0; ctrl_div_en_i = 0; ctrl_div_val_i = 0;
        cmp0_we = 0; cmp1_we = 0; cmp_wdata = 0; int_en_we = 0; int_en_i = 0;
        int_st_clr = 0; dbg_mode = 0; halt_req = 0; counter_value = 64'd0;
        tick();
        chk_reset_state("rst");
        tick();
        RST = 1'b0;

        // Control-write legality table
        foreach (vecs[i]) begin
            tick();
            ctrl_we         = 1'b1;
            ctrl_timer_en_i = vecs[i].te;
            ctrl_div_en_i   = vecs[i].de;
            ctrl_div_val_i  = vecs[i].dv;
            tick();
            ctrl_we = 1'b0;
            chk($sformatf("vec%0d_timer_en", i), timer_en, vecs[i].exp_te);
            chk($sformatf("vec%0d_div_en", i),   div_en,   vecs[i].exp_de);
            chk($sformatf("vec%0d_div_val", i),  div_val,  vecs[i].exp_dv);
            chk($sformatf("vec%0d_ctrl_err", i), ctrl_err, vecs[i].exp_err);
            tick();
            chk($sformatf("vec%0d_err_clear", i), ctrl_err, 1'b0);
        end

        // No prescale: strobe every cycle from the cycle after the enabling write
        cyc(1, 1, 0, 4'd2, 0, 0);
        mon_en = 1'b1;
        repeat (8) cyc(0, 0, 0, 4'd0, 0, 1);
        cyc(1, 0, 0, 4'd2, 0, 1);
        cyc(0, 0, 0, 4'd0, 0, 0);

        // Divide by 4: one strobe in every fourth enabled cycle
        cyc(1, 0, 1, 4'd2, 0, 0);
        cyc(1, 1, 1, 4'd2, 0, 0);
        for (int k = 1; k <= 12; k++) cyc(0, 0, 0, 4'd0, 0, (k % 4) == 0);
        cyc(1, 0, 1, 4'd2, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0);

        // Divide by 1
        cyc(1, 0, 1, 4'd0, 0, 0);
        cyc(1, 1, 1, 4'd0, 0, 0);
        repeat (5) cyc(0, 0, 0, 4'd0, 0, 1);
        cyc(1, 0, 1, 4'd0, 0, 1);
        cyc(0, 0, 0, 4'd0, 0, 0);

        // Disable at div_cnt=3 must clear the divider: re-enable needs 8 full cycles
        cyc(1, 0, 1, 4'd3, 0, 0);
        cyc(1, 1, 1, 4'd3, 0, 0);
        for (int k = 1; k <= 3; k++) cyc(0, 0, 0, 4'd0, 0, 0);
        cyc(1, 0, 1, 4'd3, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0);
        cyc(1, 1, 1, 4'd3, 0, 0);
        for (int k = 1; k <= 8; k++) cyc(0, 0, 0, 4'd0, 0, k == 8);

        // Halt for 10 cycles with the divider at 5; it resumes from 5 afterwards
        for (int j = 1; j <= 18; j++) begin
            cyc(0, 0, 0, 4'd0, (j >= 5) && (j <= 14), j == 18);
            chk($sformatf("halt_ack_j%0d", j), halt_ack, (j >= 6) && (j <= 15));
        end
        cyc(1, 0, 1, 4'd3, 0, 0);
        cyc(0, 0, 0, 4'd0, 0, 0);
        drain();

        // Compare halves and the sticky interrupt
        tick();
        cmp1_we = 1'b1; cmp_wdata = 32'hDEAD_BEEF;
        tick();
        cmp1_we = 1'b0;
        chk("cmp_hi_only", compare, 64'hDEAD_BEEF_FFFF_FFFF);
        cmp0_we = 1'b1; cmp1_we = 1'b1; cmp_wdata = 32'h10;
        tick();
        cmp0_we = 1'b0; cmp1_we = 1'b0;
        chk("cmp_both", compare, 64'h0000_0010_0000_0010);
        cmp1_we = 1'b1; cmp_wdata = 32'h0;
        tick();
        cmp1_we = 1'b0;
        chk("cmp_final", compare, 64'h0000_0000_0000_0010);
        int_en_we = 1'b1; int_en_i = 1'b1;
        tick();
        int_en_we = 1'b0;
        chk("int_en_set", int_en, 1'b1);
        chk("tim_int_idle", tim_int, 1'b0);
        counter_value = 64'h0000_0001_0000_0010;
        tick();
        chk("int_st_hi_mismatch", int_st, 1'b0);
        counter_value = 64'h10;
        tick();
        counter_value = 64'h11;
        chk("int_st_match", int_st, 1'b1);
        chk("tim_int_match", tim_int, 1'b1);
        int_en_we = 1'b1; int_en_i = 1'b0;
        tick();
        int_en_we = 1'b0;
        chk("tim_int_masked", tim_int, 1'b0);
        chk("int_st_masked", int_st, 1'b1);
        int_en_we = 1'b1; int_en_i = 1'b1;
        tick();
        int_en_we = 1'b0;
        chk("tim_int_unmasked", tim_int, 1'b1);
        int_st_clr = 1'b1;
        tick();
        int_st_clr = 1'b0;
        chk("int_st_cleared", int_st, 1'b0);
        chk("tim_int_cleared", tim_int, 1'b0);
        int_st_clr = 1'b1; counter_value = 64'h10;
        tick();
        int_st_clr = 1'b0; counter_value = 64'h11;
        chk("int_st_set_wins", int_st, 1'b1);

        // Asynchronous reset while halted
        ctrl_we = 1'b1; ctrl_timer_en_i = 1'b1; ctrl_div_en_i = 1'b1; ctrl_div_val_i = 4'd3;
        tick();
        ctrl_we = 1'b0; dbg_mode = 1'b1; halt_req = 1'b1;
        tick();
        tick();
        chk("pre_rst_halt_ack", halt_ack, 1'b1);
        chk("pre_rst_timer_en", timer_en, 1'b1);
        chk("pre_rst_cnt_en", cnt_en, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk_reset_state("async_rst");
        dbg_mode = 1'b0; halt_req = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_div_val", div_val, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing and interrupt controller for the 64-bit timer counter datapath.
- Holds the control fields (timer enable, prescaler enable and divisor), generates the timer_en and cnt_en strobes that drive the counter, and freezes counting on a debug halt.
- Holds the 64-bit compare value and raises a sticky, maskable interrupt when the counter matches it.
- Sits between the APB register decode and the counter.

Parameters:
- CNT_W, 64, counter and compare width.
- DIV_W, 4, width of the prescaler divisor field.
- DIV_MAX, 8, largest legal divisor exponent; prescaler ratio is 2^div_val.

Ports:
- CLK  in  1  single clock for the block.
- RST  in  1  asynchronous, active-high reset.
- ctrl_we  in  1  one-cycle write strobe for the control fields.
- ctrl_timer_en_i  in  1  timer_en value to write.
- ctrl_div_en_i  in  1  div_en value to write.
- ctrl_div_val_i  in  DIV_W  div_val value to write.
- cmp0_we  in  1  write strobe for compare[31:0].
- cmp1_we  in  1  write strobe for compare[63:32].
- cmp_wdata  in  32  compare write data.
- int_en_we  in  1  write strobe for int_en.
- int_en_i  in  1  int_en value to write.
- int_st_clr  in  1  write-one-to-clear pulse for int_st.
- dbg_mode  in  1  debug mode active.
- halt_req  in  1  halt request from the debugger.
- counter_value  in  CNT_W  current counter value.
- timer_en  out  1  to the counter.
- cnt_en  out  1  count strobe to the counter.
- div_en  out  1  prescaler enabled (register readback).
- div_val  out  DIV_W  divisor exponent (register readback).
- compare  out  CNT_W  compare register.
- int_en  out  1  interrupt enable.
- int_st  out  1  sticky interrupt status.
- tim_int  out  1  interrupt output, int_st & int_en.
- halt_ack  out  1  halted indication.
- ctrl_err  out  1  one-cycle pulse when a control write is rejected.

Behaviour:
- Reset values:
  - timer_en=0, div_en=0, div_val=1, compare=all ones, int_en=0, int_st=0, halt_ack=0, ctrl_err=0.
  - Internal prescaler count div_cnt (2^DIV_MAX states, 8 bits) resets to 0.
  - cnt_en=0 while timer_en=0.
- Control write (ctrl_we=1), evaluated in priority order:
  - Reject if ctrl_div_val_i > DIV_MAX: no field changes, ctrl_err=1 on the next cycle.
  - Reject if timer_en=1 and the write changes div_en or div_val: no field changes, ctrl_err=1 on the next cycle.
  - Otherwise all three fields update on the next edge.
- Halt:
  - halt_ack is registered: it is set the cycle after dbg_mode & halt_req = 1 and clears the cycle after either input falls.
  - While halt_ack=1: cnt_en=0 and div_cnt is frozen.
  - On release, counting resumes from the frozen div_cnt.
- cnt_en is combinational from registered state and is 0 when timer_en=0 or halt_ack=1. Otherwise:
  - div_en=0: cnt_en=1 every cycle.
  - div_en=1: div_cnt increments each cycle; cnt_en=1 in the cycle div_cnt == 2^div_val - 1, and div_cnt wraps to 0 on that edge.
  - div_en=1 with div_val=0: cnt_en=1 every cycle.
- Enable edges:
  - On timer_en 1→0, div_cnt clears to 0 on the same edge. The counter clears its own value.
  - On timer_en 0→1, the first cnt_en falls in the 2^div_val-th enabled cycle.
- Compare:
  - cmp0_we / cmp1_we update their halves independently; simultaneous writes update both halves.
  - match = (counter_value == compare), evaluated every cycle regardless of timer_en.
  - int_st sets on the edge after a cycle with match=1 and stays set until cleared.
  - int_st_clr clears int_st, but a set in the same cycle wins.
- tim_int = int_st & int_en (combinational, glitch-free from registered terms). Masking with int_en does not clear int_st.
- Asserting RST mid-prescale or mid-halt returns every register to its reset value immediately.

Decomposition:
- Shared package holds:
  - DIV_W, DIV_MAX, CNT_W.
  - Reset constants for compare and div_val.
  - Control-field record type (timer_en, div_en, div_val).
- One natural sub-module, timer_prescaler: owns div_cnt, takes timer_en, div_en, div_val and halt, and produces cnt_en.
- Compare, interrupt and control-write legality logic stay in the top level.

Test Plan:
- Reset, then ctrl write timer_en=1, div_en=0 → cnt_en=1 every cycle starting the cycle after the write; counter_value model increments by 1 per cycle.
- ctrl write div_en=1, div_val=2, then timer_en=1 → cnt_en pulses exactly once every 4 cycles; with div_val=0 → every cycle.
- Write div_val=3 while timer_en=1 → div_val stays 2, ctrl_err=1 for one cycle; write div_val=9 with timer_en=0 → rejected, ctrl_err pulse.
- Prescaler running with div_val=3 and div_cnt=5, assert dbg_mode=1 and halt_req=1 for 10 cycles → halt_ack=1, cnt_en=0, div_cnt held at its value; after release the next cnt_en arrives 2 cycles later.
- compare=64'h0000_0000_0000_0010, int_en=1, drive counter_value to 0x10 → int_st=1 and tim_int=1 one cycle later; int_st_clr in the same cycle as a new match → int_st remains 1.
- Drive timer_en 1→0 with div_cnt=3 → div_cnt=0 and cnt_en=0; assert RST during halt → all outputs return to reset values, with compare=all ones.
